// File: rtl/mips_file_pkg.sv
// mips_file_pkg: shared sequencer encoding and byte-lane helpers for the register file
package mips_file_pkg;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    function automatic int lanes(input int w);
        return w / 8;
    endfunction

    function automatic int lane_lo(input int i);
        return 8 * i;
    endfunction

endpackage

// File: rtl/mips_file_bank.sv
// mips_file_bank: one byte lane of one read-port copy, sync write, async read
module mips_file_bank #(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd,
    input  logic [AW-1:0] ra,
    output logic [7:0]    q
);

    logic [7:0] mem [2**AW];

    // single write port shared by scrub and user writes
    always_ff @(posedge clock) begin
        if (we) mem[wa] <= wd;
    end

    assign q = mem[ra];

endmodule

// File: rtl/mips_file_multi.sv
// mips_file_multi: multi-read-port register file with byte lanes, zero reg, bypass and reset scrub
module mips_file_multi
    import mips_file_pkg::*;
#(
    parameter int W        = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic             busy,
    input  logic [AW-1:0]    rd,
    input  logic [W/8-1:0]   we,
    input  logic [W-1:0]     D,
    input  logic [NR*AW-1:0] rs,
    output logic [NR*W-1:0]  S
);

    localparam int NL = lanes(W);

    state_t        state, state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [NL-1:0] wen;
    logic          rd_zero;
    logic [7:0]    q [NR][NL];

    // state and scrub counter; counter only advances while clearing
    always_ff @(posedge clock) begin
        state <= state_next;
        cnt   <= reset ? '0 : busy ? cnt + 1'b1 : cnt;
    end

    // leave the scrub once the last entry is cleared
    always_comb begin
        state_next = reset ? S_CLEAR : (state == S_CLEAR && cnt == '1) ? S_RUN : state;
    end

    // busy mirrors the clearing state
    always_comb begin
        busy = state == S_CLEAR;
    end

    assign rd_zero = ZERO_REG != 0 && rd == '0;
    assign wa      = busy ? cnt : rd;
    assign wd      = busy ? '0 : D;

    genvar i, j;
    generate
        for (i = 0; i < NL; i++) begin : g_lane
            assign wen[i] = !reset && (busy || (we[i] && !rd_zero));
        end
        for (j = 0; j < NR; j++) begin : g_port
            logic [AW-1:0] ra;
            logic          hit;
            assign ra  = rs[AW*j +: AW];
            assign hit = BYPASS != 0 && ra == rd && !rd_zero;
            for (i = 0; i < NL; i++) begin : g_bank
                mips_file_bank #(.AW(AW)) u_bank (
                    .clock (clock),
                    .we    (wen[i]),
                    .wa    (wa),
                    .wd    (wd[lane_lo(i) +: 8]),
                    .ra    (ra),
                    .q     (q[j][i])
                );
                assign S[W*j + lane_lo(i) +: 8] =
                    (busy || (ZERO_REG != 0 && ra == '0)) ? 8'h00 :
                    (hit && we[i]) ? D[lane_lo(i) +: 8] : q[j][i];
            end
        end
    endgenerate

endmodule

// File: tb/tb_mips_file_multi.sv
// tb_mips_file_multi: directed checks of scrub, byte lanes, zero register and bypass
module tb_mips_file_multi;

    logic        clock = 0;
    logic        reset;
    logic [4:0]  rd;
    logic [3:0]  we;
    logic [31:0] D;
    logic [9:0]  rs;
    logic        busy0, busy1;
    logic [63:0] S0, S1;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    mips_file_multi u0 (
        .clock(clock), .reset(reset), .busy(busy0), .rd(rd), .we(we), .D(D), .rs(rs), .S(S0)
    );

    mips_file_multi #(.ZERO_REG(0), .BYPASS(0)) u1 (
        .clock(clock), .reset(reset), .busy(busy1), .rd(rd), .we(we), .D(D), .rs(rs), .S(S1)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  we;
        logic [31:0] d;
        logic [9:0]  rs;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic count_scrub(input string nm);
        int   edges;
        logic gate_ok;
        edges   = 0;
        gate_ok = 1;
        while (busy0 && edges < 100) begin
            @(posedge clock);
            #1;
            edges++;
            if (busy0 && (S0 !== 64'h0 || S1 !== 64'h0)) gate_ok = 0;
        end
        chk({nm, "_edges"}, 64'(edges), 64'd32);
        chk({nm, "_gate"}, {63'h0, gate_ok}, 64'h1);
        chk({nm, "_busy1"}, {63'h0, busy1}, 64'h0);
    endtask

    initial begin
        v[0]  = '{5'd5,  4'hF, 32'hAABBCCDD, {5'd5, 5'd5},   {2{32'hAABBCCDD}}, 64'h0};
        v[1]  = '{5'd5,  4'h5, 32'h11223344, {5'd5, 5'd5},   {2{32'hAA22CC44}}, {2{32'hAABBCCDD}}};
        v[2]  = '{5'd5,  4'h0, 32'h0,        {5'd5, 5'd5},   {2{32'hAA22CC44}}, {2{32'hAA22CC44}}};
        v[3]  = '{5'd0,  4'hF, 32'hFFFFFFFF, {5'd0, 5'd0},   64'h0,             64'h0};
        v[4]  = '{5'd0,  4'h0, 32'h0,        {5'd0, 5'd0},   64'h0,             {2{32'hFFFFFFFF}}};
        v[5]  = '{5'd7,  4'hF, 32'h01020304, {5'd7, 5'd7},   {2{32'h01020304}}, 64'h0};
        v[6]  = '{5'd7,  4'h3, 32'hA0B0C0D0, {5'd5, 5'd7},   {32'hAA22CC44, 32'h0102C0D0}, {32'hAA22CC44, 32'h01020304}};
        v[7]  = '{5'd7,  4'h0, 32'h0,        {5'd5, 5'd7},   {32'hAA22CC44, 32'h0102C0D0}, {32'hAA22CC44, 32'h0102C0D0}};
        v[8]  = '{5'd3,  4'hF, 32'hDEADBEEF, {5'd3, 5'd0},   {32'hDEADBEEF, 32'h0}, {32'h0, 32'hFFFFFFFF}};
        v[9]  = '{5'd3,  4'h0, 32'h0,        {5'd3, 5'd0},   {32'hDEADBEEF, 32'h0}, {32'hDEADBEEF, 32'hFFFFFFFF}};
        v[10] = '{5'd25, 4'hF, 32'hCAFEF00D, {5'd25, 5'd25}, {2{32'hCAFEF00D}}, 64'h0};
        v[11] = '{5'd25, 4'h0, 32'h0,        {5'd25, 5'd25}, {2{32'hCAFEF00D}}, {2{32'hCAFEF00D}}};

        reset = 1; rd = 0; we = 0; D = 0; rs = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy0", {63'h0, busy0}, 64'h1);
        chk("reset_busy1", {63'h0, busy1}, 64'h1);
        chk("reset_s0", S0, 64'h0);

        @(negedge clock);
        reset = 0; rd = 5'd9; D = 32'h12345678; we = 4'hF; rs = {5'd9, 5'd9};
        count_scrub("scrub");
        @(negedge clock);
        we = 0;
        for (int e = 0; e < 32; e++) begin
            rs = {5'(e), 5'(e)};
            #1;
            chk($sformatf("clear_u0_%0d", e), S0, 64'h0);
            chk($sformatf("clear_u1_%0d", e), S1, 64'h0);
        end

        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            rd = v[k].rd; we = v[k].we; D = v[k].d; rs = v[k].rs;
            #1;
            chk($sformatf("vec%0d_u0", k), S0, v[k].e0);
            chk($sformatf("vec%0d_u1", k), S1, v[k].e1);
        end

        @(negedge clock);
        we = 0; reset = 1;
        @(posedge clock);
        #1;
        chk("midop_busy", {63'h0, busy0}, 64'h1);
        chk("midop_s_zero", S0 | S1, 64'h0);
        @(negedge clock);
        reset = 0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        chk("midscrub_busy", {63'h0, busy0}, 64'h1);
        count_scrub("rescrub");
        @(negedge clock);
        rs = {5'd25, 5'd5};
        #1;
        chk("rescrub_u0", S0, 64'h0);
        chk("rescrub_u1", S1, 64'h0);
        rs = {5'd3, 5'd0};
        #1;
        chk("rescrub_u1_r0", S1, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_file_multi.md
Name: mips_file_multi

Overview:
- Parametrised successor to the MIPS I SRAM register file.
- Generalised in data width, register count and number of read ports.
- Keeps per-byte-lane write enables and the hardwired zero register.
- Adds same-cycle write-to-read forwarding and a post-reset scrub sequencer that clears every entry, so no register holds undefined contents after reset.
- Sits in the CPU decode stage, feeding the operand latches.

Parameters:
- W, 32, data width in bits; must be a multiple of 8.
- AW, 5, address width; depth is 2**AW entries.
- NR, 2, number of independent combinational read ports (at least 1).
- ZERO_REG, 1, 1 = entry 0 always reads as zero and ignores writes.
- BYPASS, 1, 1 = a read of the register being written this cycle returns the incoming data per lane.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; starts the scrub sequence.
- busy  output  1  high while the scrub is in progress.
- rd  input  AW  write address.
- we  input  W/8  per-byte-lane write enables; bit i covers D[8i+7:8i].
- D  input  W  write data.
- rs  input  NR*AW  read addresses; port i uses rs[AW*i +: AW].
- S  output  NR*W  read data; port i drives S[W*i +: W].

Behaviour:
- One clock, named clock. Reset is synchronous and active-high, named reset. All state changes happen on the rising edge of clock.
- Storage:
  - NR copies of the array, one per read port, each split into W/8 byte lanes.
  - Every write updates all copies identically, so read ports are fully independent.
- Sequencer states, in a shared package: S_CLEAR, S_RUN.
- Sampling reset high forces:
  - state to S_CLEAR
  - scrub counter cnt to 0
  - busy to 1
  - This applies whether reset arrives at power-up, mid-scrub (the scrub restarts from 0) or mid-operation.
- S_CLEAR, on each edge with reset low:
  - write zero to all lanes of entry cnt in every copy
  - cnt <= cnt + 1
  - when cnt == 2**AW-1, clear that entry, move to S_RUN and drop busy to 0 on the same edge.
- Scrub duration: busy is high for exactly 2**AW edges after the first edge with reset low; cnt is AW bits wide.
- While busy:
  - user writes (we, rd, D) are ignored
  - every S port reads 0
- S_RUN writes: on each edge, lane i of entry rd is written with D lane i when we[i]=1. Entry 0 is never written if ZERO_REG=1.
- S_RUN reads:
  - Combinational, zero latency.
  - S port j returns the stored entry rs_j.
  - If ZERO_REG=1 and rs_j==0, it returns 0.
- Forwarding:
  - Condition: BYPASS=1, rd==rs_j, not busy, and not (ZERO_REG and rd==0).
  - Per lane, S_j lane i = D lane i when we[i]=1; otherwise the stored lane.
  - With BYPASS=0, a write becomes visible on the first read after the edge.
- Write conflicts: none possible, since there is a single write port. Any number of read ports may address the same entry at once.
- busy reset value is 1. S reset behaviour is 0 while busy.

Decomposition:
- Package mips_file_pkg holds:
  - state encoding (S_CLEAR, S_RUN)
  - the lane count function (W/8)
  - the lane slice helper
- Sub-module mips_file_bank: one byte lane, one read port, 2**AW x 8 storage, synchronous write, asynchronous read.
  - The top instantiates NR x (W/8) banks.
  - The top holds the sequencer, the write mux (scrub vs user) and the zero/bypass output logic.

Test Plan:
- Scrub timing: assert reset for 3 cycles, then release. busy stays 1 for exactly 32 edges (AW=5), then 0. After that, all 32 entries read 0x00000000 on both ports.
- Byte lanes: write rd=5, D=0xAABBCCDD, we=4'b1111, then rd=5, D=0x11223344, we=4'b0101. A read of rs=5 returns 0xAA22CC44 on both ports.
- Zero register: write rd=0, D=0xFFFFFFFF, we=4'hF. rs=0 returns 0. Repeat with ZERO_REG=0: rs=0 returns 0xFFFFFFFF after the edge.
- Bypass: entry 7 holds 0x01020304. In the same cycle drive rd=7, D=0xA0B0C0D0, we=4'b0011, rs0=7. S0 is combinationally 0x0102C0D0 before the edge. With BYPASS=0 it is 0x01020304 before the edge and 0x0102C0D0 after.
- Busy gating: during scrub, drive rd=9, D=0x12345678, we=4'hF every cycle. S reads 0 throughout. Entry 9 reads 0 after busy falls.
- Reset mid-scrub: assert reset for 1 cycle at cnt=20. The scrub restarts, busy stays high for a further 32 edges, and entry 25 (previously written) reads 0 afterwards.
